// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : hadder / serial_adder
// Description : Bit-serial adder. Operands are captured on an accepted start
//               and consumed LSB first, one bit pair per clock, through a
//               full-adder cell made of two half adders. Sum bits are shifted
//               into a partial-sum register; the carry lives in a flip-flop
//               between cycles. The completed result is published together
//               with a one-cycle done pulse.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               start  - begin an addition (sampled only in IDLE)
//               a, b   - WIDTH-bit operands, captured on accepted start
//               cin    - carry-in, captured on accepted start
//               busy   - high while bits are being processed
//               done   - one-cycle pulse, sum/cout valid while high
//               sum    - registered (a + b + cin) mod 2^WIDTH
//               cout   - registered carry-out of bit WIDTH-1
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Half adder: o_s = i_a ^ i_b, o_c = i_a & i_b
// ----------------------------------------------------------------------------
module hadder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

// ----------------------------------------------------------------------------
// Bit-serial adder top
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Index of the last bit; the edge that processes it also publishes.
    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(WIDTH - 1);
    // Single 1 in the MSB position, used to insert the new sum bit.
    localparam logic [WIDTH-1:0] c_MSB_ONE = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_psum;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    // Full-adder cell from two half adders
    logic             w_s1;
    logic             w_c1;
    logic             w_s;
    logic             w_c2;
    logic             w_carry;
    logic [WIDTH-1:0] w_psum_next;

    hadder u_ha0 (
        .i_a (r_sa[0]),
        .i_b (r_sb[0]),
        .o_s (w_s1),
        .o_c (w_c1)
    );

    hadder u_ha1 (
        .i_a (w_s1),
        .i_b (r_c),
        .o_s (w_s),
        .o_c (w_c2)
    );

    assign w_carry = w_c1 | w_c2;

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the result
    // sits at bit 0. Written without slicing so WIDTH=1 needs no special case.
    assign w_psum_next = (r_psum >> 1) | (w_s ? c_MSB_ONE : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_psum  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_c     <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_psum <= w_psum_next;
                    r_sa   <= r_sa >> 1;
                    r_sb   <= r_sb >> 1;
                    r_c    <= w_carry;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_sum   <= w_psum_next;
                        r_cout  <= w_carry;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder. Exercises a
//               WIDTH=8 instance (reset, basic add, overflow, ignored start,
//               mid-operation reset), a WIDTH=4 instance exhaustively and a
//               WIDTH=1 instance for the single-bit corner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk;
    logic rst_n;

    // WIDTH=8 instance
    logic       r_start8;
    logic [7:0] r_a8;
    logic [7:0] r_b8;
    logic       r_cin8;
    logic       w_busy8;
    logic       w_done8;
    logic [7:0] w_sum8;
    logic       w_cout8;

    // WIDTH=4 instance
    logic       r_start4;
    logic [3:0] r_a4;
    logic [3:0] r_b4;
    logic       r_cin4;
    logic       w_busy4;
    logic       w_done4;
    logic [3:0] w_sum4;
    logic       w_cout4;

    // WIDTH=1 instance
    logic       r_start1;
    logic [0:0] r_a1;
    logic [0:0] r_b1;
    logic       r_cin1;
    logic       w_busy1;
    logic       w_done1;
    logic [0:0] w_sum1;
    logic       w_cout1;

    int n_tests;
    int n_fail;

    logic [7:0] r_prev_sum8;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (r_start8),
        .a     (r_a8),
        .b     (r_b8),
        .cin   (r_cin8),
        .busy  (w_busy8),
        .done  (w_done8),
        .sum   (w_sum8),
        .cout  (w_cout8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (r_start4),
        .a     (r_a4),
        .b     (r_b4),
        .cin   (r_cin4),
        .busy  (w_busy4),
        .done  (w_done4),
        .sum   (w_sum4),
        .cout  (w_cout4)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (r_start1),
        .a     (r_a1),
        .b     (r_b1),
        .cin   (r_cin1),
        .busy  (w_busy1),
        .done  (w_done1),
        .sum   (w_sum1),
        .cout  (w_cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 addition with cycle-by-cycle checks. With disturb set,
    // start is pulsed and the operand inputs are zeroed during RUN.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] exp_sum, input logic exp_cout,
                        input bit disturb);
        r_a8     = a;
        r_b8     = b;
        r_cin8   = cin;
        r_start8 = 1'b1;
        tick();                                   // E0
        r_start8 = 1'b0;
        check("add8 busy after E0", {31'd0, w_busy8}, 32'd1);
        for (int k = 1; k <= 7; k++) begin
            if (disturb && k == 2) begin
                r_start8 = 1'b1;
                r_a8     = 8'h00;
                r_b8     = 8'h00;
                r_cin8   = 1'b0;
            end
            if (disturb && k == 4) r_start8 = 1'b0;
            tick();                               // E1..E7
            check("add8 busy in run", {31'd0, w_busy8}, 32'd1);
            check("add8 no early done", {31'd0, w_done8}, 32'd0);
            check("add8 sum held", {24'd0, w_sum8}, {24'd0, r_prev_sum8});
        end
        r_start8 = 1'b0;
        tick();                                   // E8
        check("add8 done", {31'd0, w_done8}, 32'd1);
        check("add8 busy low in done", {31'd0, w_busy8}, 32'd0);
        check("add8 sum", {24'd0, w_sum8}, {24'd0, exp_sum});
        check("add8 cout", {31'd0, w_cout8}, {31'd0, exp_cout});
        tick();                                   // E9
        check("add8 done one cycle", {31'd0, w_done8}, 32'd0);
        check("add8 busy idle", {31'd0, w_busy8}, 32'd0);
        check("add8 sum kept", {24'd0, w_sum8}, {24'd0, exp_sum});
        r_prev_sum8 = exp_sum;
    endtask

    initial begin
        logic [4:0] exp5;
        logic [1:0] exp2;

        n_tests     = 0;
        n_fail      = 0;
        r_prev_sum8 = 8'h00;
        rst_n       = 1'b0;
        r_start8 = 1'b0; r_a8 = '0; r_b8 = '0; r_cin8 = 1'b0;
        r_start4 = 1'b0; r_a4 = '0; r_b4 = '0; r_cin4 = 1'b0;
        r_start1 = 1'b0; r_a1 = '0; r_b1 = '0; r_cin1 = 1'b0;

        // Reset
        tick();
        tick();
        check("reset busy", {31'd0, w_busy8}, 32'd0);
        check("reset done", {31'd0, w_done8}, 32'd0);
        check("reset sum", {24'd0, w_sum8}, 32'd0);
        check("reset cout", {31'd0, w_cout8}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("idle busy", {31'd0, w_busy8}, 32'd0);
        check("idle done", {31'd0, w_done8}, 32'd0);
        check("idle sum", {24'd0, w_sum8}, 32'd0);
        check("idle cout", {31'd0, w_cout8}, 32'd0);

        // Basic, overflow, carry-in, ignored start with operand change
        add8(8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0, 1'b0);
        add8(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
        add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);
        add8(8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0, 1'b1);
        tick();
        check("no extra done", {31'd0, w_done8}, 32'd0);
        check("no restart busy", {31'd0, w_busy8}, 32'd0);

        // Reset in the middle of an operation (between E4 and E5)
        r_a8 = 8'hFF; r_b8 = 8'hFF; r_cin8 = 1'b1; r_start8 = 1'b1;
        tick();
        r_start8 = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, w_busy8}, 32'd0);
        check("midreset sum", {24'd0, w_sum8}, 32'd0);
        check("midreset cout", {31'd0, w_cout8}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("midreset no done", {31'd0, w_done8}, 32'd0);
        end
        r_prev_sum8 = 8'h00;
        add8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // WIDTH=4 exhaustive, each start issued the cycle after done
        for (int i = 0; i < 512; i++) begin
            r_a4     = i[3:0];
            r_b4     = i[7:4];
            r_cin4   = i[8];
            exp5     = {1'b0, i[3:0]} + {1'b0, i[7:4]} + {4'd0, i[8]};
            r_start4 = 1'b1;
            tick();                               // E0
            r_start4 = 1'b0;
            for (int k = 1; k <= 4; k++) tick();  // E1..E4
            check("w4 done/cout/sum", {26'd0, w_done4, w_cout4, w_sum4},
                  {26'd0, 1'b1, exp5});
            tick();                               // E5, back to IDLE
        end

        // WIDTH=1: done follows at E1
        for (int i = 0; i < 8; i++) begin
            r_a1     = i[0];
            r_b1     = i[1];
            r_cin1   = i[2];
            exp2     = {1'b0, i[0]} + {1'b0, i[1]} + {1'b0, i[2]};
            r_start1 = 1'b1;
            tick();                               // E0
            r_start1 = 1'b0;
            check("w1 busy", {31'd0, w_busy1}, 32'd1);
            tick();                               // E1
            check("w1 done/cout/sum", {29'd0, w_done1, w_cout1, w_sum1},
                  {29'd0, 1'b1, exp2});
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial multi-bit adder that feeds the half-adder stage. Each cycle it presents one operand bit pair, LSB first, to a full-adder cell.
- The full-adder cell is built from two hadder instances: carry = cout1 | cout2.
- The block shifts each sum bit into a result register and holds the carry in a flip-flop between cycles.
- It sits between a start/operand source (testbench or datapath controller) and any consumer of a WIDTH-bit sum plus carry-out.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset. Assertion is asynchronous; release is sampled on clk.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- cin  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum and cout are valid while done is high.
- sum  output  WIDTH  registered result (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of bit WIDTH-1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry flip-flop and bit counter are all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: capture a, b, cin into sa, sb and the carry flip-flop, set cnt=0, go to RUN.
  - With start=0: stay in IDLE.
- RUN:
  - busy=1.
  - Each edge computes s = sa[0]^sb[0]^c and c' = majority(sa[0], sb[0], c) via two hadder instances plus an OR.
  - On that edge: shift s into the MSB of the partial-sum register, shift sa and sb right by 1, set c=c', cnt=cnt+1.
  - On the edge where cnt==WIDTH-1: copy the completed partial sum into sum, copy c' into cout, go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - The next edge returns unconditionally to IDLE.
  - start is ignored in DONE.
- Latency:
  - start is accepted at edge E0.
  - Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
  - done is high between edges E_WIDTH and E_WIDTH+1.
  - Back-to-back operations: the next accepted start is no earlier than edge E_WIDTH+2.
- Output stability:
  - sum and cout change only on the RUN-to-DONE transition.
  - They hold their previous result throughout IDLE and RUN, and until the next completion.
- start while busy or done: ignored, with no effect on operands or state.
- a, b, cin changes after acceptance: no effect on the operation in progress.
- cnt is sized to $clog2(WIDTH)+1 bits and does not wrap within an operation.
- WIDTH=1: RUN lasts exactly one edge; done follows at E1.
- Overflow: cout=1 whenever a+b+cin ≥ 2^WIDTH; sum holds the truncated value.
- Reset mid-operation: the operation is aborted immediately and all outputs return to their reset values. No done pulse is produced for the aborted operation.
- No combinational path exists from any input to any output.

Test Plan:
- Reset with WIDTH=8: hold rst_n=0 for 2 cycles -> busy=0, done=0, sum=0x00, cout=0. Release, then idle 3 cycles -> outputs unchanged.
- Basic add, WIDTH=8: a=0x35, b=0x0A, cin=0, start pulse at E0 -> busy high for E1..E8, done high after E8, sum=0x3F, cout=0. Check the done pulse lasts exactly 1 cycle.
- Overflow and cin: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1 after 8 RUN cycles. Then a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1.
- Ignored start and operand change: during RUN, pulse start and change a to 0x00, b to 0x00. Required: the result is unaffected (sum=0x3F for the basic case), no extra done pulse, and the previous sum is held until completion.
- Reset mid-op: assert rst_n=0 asynchronously between E4 and E5 -> busy and sum drop to 0 before the next edge. After release, a new add of 0x12+0x34 yields sum=0x46, cout=0.
- Exhaustive check: WIDTH=4, all 512 combinations of {a, b, cin}, issuing each start in the cycle after done -> every sum/cout matches a+b+cin.
